// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The trailer checksum feature is selected by IMEM_LOADER_CHKSUM_EN.
package imem_loader_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      CHK,
      DONE,
      ERR
   } state_t;

   // A usable image carries between 1 and max_words payload words.
   function automatic logic hdr_ok(input logic [WORD_W-1:0] n,
                                   input logic [WORD_W-1:0] max_words);
      return (n != '0) && (n <= max_words);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: shift register plus 2-bit byte counter.
// word/word_valid present the completed word in the cycle its last byte is taken.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              take,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   // Only the three most recent bytes need storage; the fourth is the live input.
   logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
   logic [1:0]               cnt_q, cnt_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (take) begin
         shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   assign word       = {shift_q, byte_in};
   assign word_valid = take && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, payload words to imem, CPU held until loaded.
// Defining IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum word (CHK state).
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | collecting the 4-byte payload word count
// LOAD  | collecting payload words, one imem write per word
// CHK   | collecting the 4-byte XOR trailer (checksum build only)
// DONE  | image loaded, core released
// ERR   | bad header or checksum, core held
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [BYTE_W-1:0] s_byte,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

   state_t              state_q, state_d;
   logic                s_ready_q, s_ready_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
`ifdef IMEM_LOADER_CHKSUM_EN
   logic [WORD_W-1:0]   xor_q, xor_d;
`endif

   logic                take;
   logic                restart;
   logic [WORD_W-1:0]   pk_word;
   logic                pk_valid;

   assign take = s_valid && s_ready_q;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (restart),
      .byte_in    (s_byte),
      .take       (take),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_comb begin
      state_d      = state_q;
      s_ready_d    = s_ready_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_hold_d   = cpu_hold_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      n_d          = n_q;
      idx_d        = idx_q;
      restart      = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      xor_d        = xor_q;
`endif

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               restart    = 1'b1;
               state_d    = HDR;
               s_ready_d  = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               cpu_hold_d = 1'b1;
            end
         end

         HDR: begin
            if (pk_valid) begin
               if (hdr_ok(pk_word, WORD_W'(MAX_WORDS))) begin
                  state_d = LOAD;
                  n_d     = CNT_W'(pk_word);
                  idx_d   = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                  xor_d   = '0;
`endif
               end else begin
                  state_d    = ERR;
                  s_ready_d  = 1'b0;
                  busy_d     = 1'b0;
                  err_d      = 1'b1;
                  cpu_hold_d = 1'b1;
               end
            end
         end

         LOAD: begin
            if (pk_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = BASE + ADDR_W'(idx_q);
               imem_wdata_d = pk_word;
               idx_d        = idx_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHKSUM_EN
               xor_d        = xor_q ^ pk_word;
`endif
            end else if (imem_we_q && (idx_q == n_q)) begin
               // Leave only once the final write pulse is on the port, so the
               // status flags trail that pulse by exactly one cycle.
`ifdef IMEM_LOADER_CHKSUM_EN
               state_d    = CHK;
`else
               state_d    = DONE;
               s_ready_d  = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
`endif
            end
         end

`ifdef IMEM_LOADER_CHKSUM_EN
         CHK: begin
            if (pk_valid) begin
               s_ready_d = 1'b0;
               busy_d    = 1'b0;
               if (pk_word == xor_q) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d    = ERR;
                  err_d      = 1'b1;
                  cpu_hold_d = 1'b1;
               end
            end
         end
`endif

         default: begin
            state_d   = IDLE;
            s_ready_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= BASE;
         imem_wdata_q <= '0;
         cpu_hold_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         n_q          <= '0;
         idx_q        <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
         xor_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         s_ready_q    <= s_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
`ifdef IMEM_LOADER_CHKSUM_EN
         xor_q        <= xor_d;
`endif
      end
   end

   assign s_ready    = s_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default instance and a 2-bit-address instance at base 3
// share one stimulus stream; trailer bytes are sent when IMEM_LOADER_CHKSUM_EN is set.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  s_byte;
   logic        s_valid;

   logic        a_s_ready, a_we, a_hold, a_busy, a_done, a_err;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic        b_s_ready, b_we, b_hold, b_busy, b_done, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;

   always #5 clk = ~clk;

   imem_loader u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .s_byte     (s_byte),
      .s_valid    (s_valid),
      .s_ready    (a_s_ready),
      .imem_we    (a_we),
      .imem_addr  (a_addr),
      .imem_wdata (a_wdata),
      .cpu_hold   (a_hold),
      .busy       (a_busy),
      .done       (a_done),
      .err        (a_err)
   );

   imem_loader #(.ADDR_W(2), .BASE_ADDR(3), .MAX_WORDS(256)) u_wrap (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .s_byte     (s_byte),
      .s_valid    (s_valid),
      .s_ready    (b_s_ready),
      .imem_we    (b_we),
      .imem_addr  (b_addr),
      .imem_wdata (b_wdata),
      .cpu_hold   (b_hold),
      .busy       (b_busy),
      .done       (b_done),
      .err        (b_err)
   );

   int checks   = 0;
   int failures = 0;

   // Write log and timing observations, sampled mid-cycle.
   int          cyc        = 0;
   logic [39:0] qa[$];
   logic [33:0] qb[$];
   int          last_we    = -1;
   int          done_rise  = -1;
   int          pulse_viol = 0;
   int          hold_viol  = 0;
   logic        a_we_prev  = 1'b0;
   logic        b_we_prev  = 1'b0;
   logic        a_done_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_we) begin
         qa.push_back({a_addr, a_wdata});
         last_we = cyc;
         if (a_we_prev) pulse_viol++;
      end
      if (b_we) begin
         qb.push_back({b_addr, b_wdata});
         if (b_we_prev) pulse_viol++;
      end
      if (a_done && !a_done_prev) done_rise = cyc;
      if ((a_busy && !a_hold) || (b_busy && !b_hold)) hold_viol++;
      a_we_prev   = a_we;
      b_we_prev   = b_we;
      a_done_prev = a_done;
   end

   typedef struct {
      string       name;
      logic [31:0] hdr;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          stall;
      bit          start_mid;
      bit          bad_trl;
      bit          hdr_err;
   } vec_t;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_s_ready"},  40'(a_s_ready), 40'd0);
      chk({tag, "_we"},       40'(a_we),      40'd0);
      chk({tag, "_addr"},     40'(a_addr),    40'd0);
      chk({tag, "_wdata"},    40'(a_wdata),   40'd0);
      chk({tag, "_cpu_hold"}, 40'(a_hold),    40'd1);
      chk({tag, "_busy"},     40'(a_busy),    40'd0);
      chk({tag, "_done"},     40'(a_done),    40'd0);
      chk({tag, "_err"},      40'(a_err),     40'd0);
      chk({tag, "_b_addr"},   40'(b_addr),    40'd3);
      chk({tag, "_b_hold"},   40'(b_hold),    40'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard;
      if (stall) begin
         s_valid = 1'b0;
         repeat (2) @(negedge clk);
      end
      s_byte  = b;
      s_valid = 1'b1;
      guard   = 0;
      while (a_s_ready !== 1'b1 && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      chk("s_ready_wait", 40'(a_s_ready), 40'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] w[2];
      logic [31:0] trl;
      bit          exp_err;
      int          exp_n, n0a, n0b, pv0, hv0, guard, got_a, got_b;
      w[0]    = v.w0;
      w[1]    = v.w1;
      exp_err = v.hdr_err;
`ifdef IMEM_LOADER_CHKSUM_EN
      exp_err = exp_err | v.bad_trl;
`endif
      exp_n = v.hdr_err ? 0 : v.nw;
      n0a   = qa.size();
      n0b   = qb.size();
      pv0   = pulse_viol;
      hv0   = hold_viol;

      pulse_start();
      chk({v.name, "_start_busy"}, 40'(a_busy),    40'd1);
      chk({v.name, "_start_hold"}, 40'(a_hold),    40'd1);
      chk({v.name, "_start_done"}, 40'(a_done),    40'd0);
      chk({v.name, "_start_err"},  40'(a_err),     40'd0);
      chk({v.name, "_start_rdy"},  40'(a_s_ready), 40'd1);

      for (int k = 0; k < 4; k++) send_byte(v.hdr[31-8*k -: 8], v.stall);
      for (int i = 0; i < v.nw; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (v.start_mid && i == 0 && k == 1) start = 1'b1;
            send_byte(w[i][31-8*k -: 8], v.stall);
            start = 1'b0;
         end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      if (!v.hdr_err && v.nw > 0) begin
         trl = '0;
         for (int i = 0; i < v.nw; i++) trl = trl ^ w[i];
         if (v.bad_trl) trl = trl ^ 32'h1;
         for (int k = 0; k < 4; k++) send_byte(trl[31-8*k -: 8], v.stall);
      end
`endif

      guard = 0;
      while (!(a_done || a_err) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);

      chk({v.name, "_done"},     40'(a_done),    40'(!exp_err));
      chk({v.name, "_err"},      40'(a_err),     40'(exp_err));
      chk({v.name, "_cpu_hold"}, 40'(a_hold),    40'(exp_err));
      chk({v.name, "_busy"},     40'(a_busy),    40'd0);
      chk({v.name, "_s_ready"},  40'(a_s_ready), 40'd0);
      chk({v.name, "_b_done"},   40'(b_done),    40'(!exp_err));
      chk({v.name, "_b_err"},    40'(b_err),     40'(exp_err));
      chk({v.name, "_b_hold"},   40'(b_hold),    40'(exp_err));
      chk({v.name, "_b_busy"},   40'(b_busy),    40'd0);
      chk({v.name, "_b_rdy"},    40'(b_s_ready), 40'd0);

      got_a = qa.size() - n0a;
      got_b = qb.size() - n0b;
      chk({v.name, "_nwrites"},   40'(got_a), 40'(exp_n));
      chk({v.name, "_b_nwrites"}, 40'(got_b), 40'(exp_n));
      for (int i = 0; i < exp_n && i < got_a; i++)
         chk({v.name, "_write"}, qa[n0a+i], {8'(i), w[i]});
      for (int i = 0; i < exp_n && i < got_b; i++)
         chk({v.name, "_b_write"}, 40'(qb[n0b+i]), 40'({2'(3 + i), w[i]}));
`ifndef IMEM_LOADER_CHKSUM_EN
      if (!exp_err) chk({v.name, "_done_timing"}, 40'(done_rise), 40'(last_we + 1));
`endif
      chk({v.name, "_we_pulse"},  40'(pulse_viol), 40'(pv0));
      chk({v.name, "_hold_busy"}, 40'(hold_viol),  40'(hv0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t fresh;
      int   n0a, n0b;

      //           name        hdr           nw  w0            w1            stall mid bad  hdr_err
      vecs[0] = '{"normal",    32'h00000002, 2, 32'h20080005, 32'h8C090004, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"stall",     32'h00000002, 2, 32'h20080005, 32'h8C090004, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{"zero_hdr",  32'h00000000, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{"big_hdr",   32'h00000101, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{"mid_start", 32'h00000002, 2, 32'h11223344, 32'hA5A55A5A, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"single",    32'h00000001, 1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"bad_trl",   32'h00000002, 2, 32'h20080005, 32'h8C090004, 1'b0, 1'b0, 1'b1, 1'b0};

      reset   = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_byte  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("por");
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the middle of word 1 of a maximum-size (N=256) image.
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(32'h00000100 >> (24 - 8*k)), 1'b0);
      n0a = qa.size();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h06, 1'b0);
      chk("maxhdr_busy", 40'(a_busy), 40'd1);
      chk("maxhdr_err",  40'(a_err),  40'd0);
      chk("maxhdr_word0", 40'(qa.size() - n0a), 40'd1);
      #2 reset = 1'b1;
      #1 check_reset_vals("midrst");
      n0a = qa.size();
      n0b = qb.size();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_we",   40'(qa.size() - n0a), 40'd0);
      chk("midrst_b_no_we", 40'(qb.size() - n0b), 40'd0);
      chk("midrst_idle_hold", 40'(a_hold), 40'd1);

      fresh      = vecs[0];
      fresh.name = "fresh";
      run_vec(fresh);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch path reads.
- Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instructions, and writes them to consecutive word addresses.
- Holds the CPU core in reset (cpu_hold) until the image is fully loaded.
- Sits between the external boot port and the instruction memory write port.

Parameters:
- ADDR_W, 8, width of the instruction memory word address.
- BASE_ADDR, 0, first word address written.
- MAX_WORDS, 256, largest legal payload word count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only
- s_byte  in  8  stream data byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction memory write enable, one-cycle pulse
- imem_addr  out  ADDR_W  instruction memory word address
- imem_wdata  out  32  instruction word to write
- cpu_hold  out  1  high keeps the core in reset
- busy  out  1  load in progress
- done  out  1  image loaded OK; sticky until next start
- err  out  1  load failed; sticky until next start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: s_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0. State=IDLE; byte and word counters cleared.
- Byte acceptance: a byte is taken on any cycle where s_valid=1 and s_ready=1. s_ready=1 in HDR, LOAD and CHK; 0 in IDLE, DONE and ERR.
- Byte packing: big-endian. The first byte of each group lands in bits [31:24], the fourth in [7:0].
- States:
  - IDLE: on start, go to HDR with busy=1, done=0, err=0, cpu_hold=1.
  - HDR: collect 4 bytes into the payload word count N.
    - If N==0 or N>MAX_WORDS: go to ERR.
    - Otherwise: go to LOAD, with word index=0.
  - LOAD: when the 4th byte of a word is accepted, on the next cycle imem_we=1 for exactly one cycle, with imem_addr=(BASE_ADDR+index) mod 2^ADDR_W and imem_wdata=the packed word. Index then increments.
    - s_ready stays 1 throughout; the following word cannot complete within 3 cycles, so writes never collide.
    - After the write of word N-1: go to CHK if the option is compiled in, else DONE.
  - DONE: done=1, busy=0, cpu_hold=0. These assert the cycle after the final imem_we pulse.
  - ERR: err=1, busy=0, cpu_hold=1.
- start while busy: ignored.
- start in DONE or ERR: restarts at HDR. cpu_hold re-asserts the next cycle.
- Address wrap: when BASE_ADDR+N exceeds 2^ADDR_W, the address wraps modulo 2^ADDR_W. Not an error.
- Stream stall: s_valid low for any number of cycles pauses progress. There is no timeout.
- Reset mid-load: all registers return to reset values and partial words are discarded. Words already written to memory are not rolled back.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- Defined:
  - After the N payload words, state CHK collects 4 more bytes (big-endian).
  - These are compared against the running XOR of all N payload words; the header is excluded.
  - Match: go to DONE.
  - Mismatch: go to ERR. Written words remain in memory and cpu_hold stays 1.
- Undefined: no CHK state and no XOR register. DONE follows the last write directly.

Decomposition:
- Package imem_loader_pkg:
  - state enum: IDLE, HDR, LOAD, CHK, DONE, ERR
  - WORD_W=32, BYTE_W=8
  - BYTES_PER_WORD=4
- Sub-module byte_packer: shift register plus 2-bit byte counter.
  - Inputs: byte and take.
  - Outputs: word and a one-cycle word_valid.
  - Cleared by reset or by a restart pulse from the FSM.

Test Plan:
- Normal load, BASE_ADDR=0: after reset, start, then stream header 00 00 00 02 and payload 20 08 00 05 8C 09 00 04 with s_valid held high.
  - Expect imem_we pulses at addr 0 (wdata 0x20080005) and addr 1 (wdata 0x8C090004).
  - Then done=1, cpu_hold=0 on the following cycle; cpu_hold stays 1 before that.
- Backpressure/stall: same image with s_valid toggled 1,0,0,1 per byte.
  - Expect identical writes and data, only delayed. No byte is lost or duplicated.
- Bad header: header 00 00 00 00.
  - Expect err=1, done=0, cpu_hold=1, no imem_we.
  - With MAX_WORDS=256, header 00 00 01 01 also gives ERR.
- Wrap and restart: ADDR_W=2, BASE_ADDR=3, N=2.
  - Expect writes to addr 3 then addr 0.
  - A start pulse during LOAD is ignored; start in DONE re-raises cpu_hold and a second image loads.
- Reset mid-load: assert reset after 2 bytes of payload word 1.
  - Expect all outputs at reset values immediately (asynchronously), and no further imem_we.
  - A fresh start loads cleanly.
- Checksum (IMEM_LOADER_CHKSUM_EN defined): payload 0x20080005, 0x8C090004.
  - Trailer AC 01 00 01 gives done=1.
  - Trailer AC 01 00 00 gives err=1 with cpu_hold=1.
